// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with split-transaction parking and a forced-release grant timeout.
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin ties; otherwise master 1 has fixed priority.
module bus_arbiter #(
   parameter int unsigned TIMEOUT = 200
) (
   input  logic clk,
   input  logic reset,
   input  logic m1_request,
   input  logic m2_request,
   input  logic trans_done,
   input  logic split_enable,
   input  logic split_release,
   output logic m1_grant,
   output logic m2_grant,
   output logic bus_busy,
   output logic split_pending,
   output logic timeout_err
);

   localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StOwnM1, StOwnM2} state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       split_pending_q, split_pending_d;
   logic       split_master_q, split_master_d;  // 0: m1, 1: m2
   logic       split_rel_q, split_rel_d;
   logic       m1_grant_q, m1_grant_d;
   logic       m2_grant_q, m2_grant_d;
   logic       bus_busy_q, bus_busy_d;
   logic       timeout_err_q, timeout_err_d;

   logic rel_seen;
   logic elig_m1, elig_m2, any_elig;
   logic regrant;
   logic tie_m2;
   logic pick_m2;
   logic owning;
   logic owner_req;
   logic timeout_hit;
   logic split_take;
   logic release_bus;

   // Arbitration and release conditions.
   always_comb begin
      rel_seen    = split_rel_q | split_release;
      elig_m1     = m1_request & ~(split_pending_q & ~split_master_q & ~rel_seen);
      elig_m2     = m2_request & ~(split_pending_q & split_master_q & ~rel_seen);
      any_elig    = elig_m1 | elig_m2;
      regrant     = split_pending_q & rel_seen & (split_master_q ? m2_request : m1_request);

      if (regrant) begin
         pick_m2 = split_master_q;
      end else if (elig_m1 && elig_m2) begin
         pick_m2 = tie_m2;
      end else begin
         pick_m2 = elig_m2;
      end

      owning      = (state_q != StIdle);
      owner_req   = (state_q == StOwnM2) ? m2_request : m1_request;
      timeout_hit = (cnt_q == CntMax);
      // Only one split may be outstanding; trans_done takes precedence over a split.
      split_take  = split_enable & ~trans_done & ~split_pending_q;
      release_bus = trans_done | ~owner_req | split_take | timeout_hit;
   end

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
   logic prio_m2_q, prio_m2_d;

   always_comb begin
      prio_m2_d = prio_m2_q;
      if (state_q == StIdle && any_elig) begin
         prio_m2_d = ~pick_m2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_m2_q <= 1'b0;
      end else begin
         prio_m2_q <= prio_m2_d;
      end
   end

   assign tie_m2 = prio_m2_q;
`else
   assign tie_m2 = 1'b0;
`endif

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (any_elig) begin
               state_d = pick_m2 ? StOwnM2 : StOwnM1;
            end
         end
         StOwnM1, StOwnM2: begin
            if (release_bus) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Busy counter and split bookkeeping.
   always_comb begin
      cnt_d           = '0;
      split_pending_d = split_pending_q;
      split_master_d  = split_master_q;
      split_rel_d     = split_rel_q;

      if (owning && !release_bus) begin
         cnt_d = cnt_q + 8'd1;
      end
      if (split_pending_q && split_release) begin
         split_rel_d = 1'b1;
      end
      if (owning && split_take) begin
         split_pending_d = 1'b1;
         split_master_d  = (state_q == StOwnM2);
         split_rel_d     = 1'b0;
      end
      if (!owning && regrant) begin
         split_pending_d = 1'b0;
         split_rel_d     = 1'b0;
      end
   end

   // Output logic: next values of the registered outputs.
   always_comb begin
      m1_grant_d    = (state_d == StOwnM1);
      m2_grant_d    = (state_d == StOwnM2);
      bus_busy_d    = m1_grant_d | m2_grant_d;
      timeout_err_d = owning & timeout_hit;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= StIdle;
         cnt_q           <= '0;
         split_pending_q <= 1'b0;
         split_master_q  <= 1'b0;
         split_rel_q     <= 1'b0;
         m1_grant_q      <= 1'b0;
         m2_grant_q      <= 1'b0;
         bus_busy_q      <= 1'b0;
         timeout_err_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         split_pending_q <= split_pending_d;
         split_master_q  <= split_master_d;
         split_rel_q     <= split_rel_d;
         m1_grant_q      <= m1_grant_d;
         m2_grant_q      <= m2_grant_d;
         bus_busy_q      <= bus_busy_d;
         timeout_err_q   <= timeout_err_d;
      end
   end

   assign m1_grant      = m1_grant_q;
   assign m2_grant      = m2_grant_q;
   assign bus_busy      = bus_busy_q;
   assign split_pending = split_pending_q;
   assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios then random traffic against a
// behavioural model of ownership, split parking and timeout.
module tb_bus_arbiter;

   localparam int unsigned TO = 4;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
   localparam bit RrMode = 1'b1;
`else
   localparam bit RrMode = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic m1_request, m2_request, trans_done, split_enable, split_release;
   logic m1_grant, m2_grant, bus_busy, split_pending, timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: owner 0 = none, 1 = m1, 2 = m2.
   int e_owner;
   int e_count;
   int e_pm;
   int e_last;
   bit e_pend;
   bit e_rel;
   bit e_tout;

   bus_arbiter #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .m1_request   (m1_request),
      .m2_request   (m2_request),
      .trans_done   (trans_done),
      .split_enable (split_enable),
      .split_release(split_release),
      .m1_grant     (m1_grant),
      .m2_grant     (m2_grant),
      .bus_busy     (bus_busy),
      .split_pending(split_pending),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      e_owner = 0;
      e_count = 0;
      e_pm    = 1;
      e_last  = 2;
      e_pend  = 0;
      e_rel   = 0;
      e_tout  = 0;
   endtask

   task automatic model_edge();
      bit req  [1:2];
      bit elig [1:2];
      int win;
      bit split_ok;
      req[1] = m1_request;
      req[2] = m2_request;
      e_tout = 0;
      if (e_pend && split_release) e_rel = 1;
      if (e_owner == 0) begin
         for (int i = 1; i <= 2; i++) elig[i] = req[i] && !(e_pend && e_pm == i && !e_rel);
         win = 0;
         if (e_pend && e_rel && req[e_pm]) begin
            win    = e_pm;
            e_pend = 0;
            e_rel  = 0;
         end else if (elig[1] && elig[2]) begin
            win = (RrMode && e_last == 1) ? 2 : 1;
         end else if (elig[1]) begin
            win = 1;
         end else if (elig[2]) begin
            win = 2;
         end
         if (win != 0) begin
            e_owner = win;
            e_count = 0;
            e_last  = win;
         end
      end else begin
         e_tout   = (e_count == int'(TO) - 1);
         split_ok = split_enable && !trans_done && !e_pend;
         if (split_ok) begin
            e_pend = 1;
            e_pm   = e_owner;
            e_rel  = 0;
         end
         if (trans_done || !req[e_owner] || split_ok || e_tout) e_owner = 0;
         else e_count++;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".m1_grant"}, m1_grant, logic'(e_owner == 1));
      check({tag, ".m2_grant"}, m2_grant, logic'(e_owner == 2));
      check({tag, ".bus_busy"}, bus_busy, logic'(e_owner != 0));
      check({tag, ".split_pending"}, split_pending, logic'(e_pend));
      check({tag, ".timeout_err"}, timeout_err, logic'(e_tout));
      check({tag, ".excl"}, m1_grant & m2_grant, 1'b0);
   endtask

   // One clock: model follows the edge, outputs checked 1 time unit later, pulses cleared.
   task automatic tick(input string tag);
      @(posedge clk);
      if (reset) model_reset();
      else model_edge();
      #1;
      check_all(tag);
      trans_done    = 1'b0;
      split_enable  = 1'b0;
      split_release = 1'b0;
   endtask

   initial begin
      reset = 1'b0; m1_request = 1'b0; m2_request = 1'b0;
      trans_done = 1'b0; split_enable = 1'b0; split_release = 1'b0;
      #1 reset = 1'b1;
      #1;
      model_reset();
      check_all("reset_async");
      tick("reset_hold");
      reset = 1'b0;
      tick("idle");

      // Both request: m1 first, one idle cycle, then m2.
      m1_request = 1'b1; m2_request = 1'b1;
      tick("both_req");
      check("both_req.m1_first", m1_grant, 1'b1);
      trans_done = 1'b1;
      tick("m1_done");
      check("m1_done.drop", m1_grant, 1'b0);
      m1_request = 1'b0;
      tick("m2_after_idle");
      check("m2_after_idle.grant", m2_grant, 1'b1);
      trans_done = 1'b1;
      tick("m2_done");
      m2_request = 1'b0;
      tick("idle2");
      m1_request = 1'b1;
      tick("m1_alone");
      trans_done = 1'b1; m2_request = 1'b1;
      tick("m1_done2");
      tick("contend2");
      trans_done = 1'b1;
      tick("contend2_done");
      m1_request = 1'b0; m2_request = 1'b0;
      tick("idle3");

      // m2 splits, m1 takes the bus, m2 waits until released.
      m2_request = 1'b1;
      tick("m2_own");
      split_enable = 1'b1;
      tick("m2_split");
      check("m2_split.grant", m2_grant, 1'b0);
      check("m2_split.pending", split_pending, 1'b1);
      m1_request = 1'b1;
      tick("m1_during_split");
      check("m1_during_split.grant", m1_grant, 1'b1);
      split_enable = 1'b1;
      tick("split_while_pending");
      check("split_while_pending.keep", m1_grant, 1'b1);
      split_release = 1'b1;
      tick("release_latched");
      trans_done = 1'b1;
      tick("m1_done3");
      tick("m2_regrant");
      check("m2_regrant.grant", m2_grant, 1'b1);
      check("m2_regrant.pending", split_pending, 1'b0);
      trans_done = 1'b1;
      tick("m2_done3");
      m1_request = 1'b0; m2_request = 1'b0;
      tick("idle4");

      // m1 splits, m2 owns, release, m1 regranted over a held m2 request.
      m1_request = 1'b1;
      tick("m1_own");
      split_enable = 1'b1;
      tick("m1_split");
      m2_request = 1'b1;
      tick("m2_during_split");
      check("m2_during_split.grant", m2_grant, 1'b1);
      split_release = 1'b1;
      tick("release2");
      trans_done = 1'b1;
      tick("m2_done4");
      tick("m1_regrant");
      check("m1_regrant.grant", m1_grant, 1'b1);
      check("m1_regrant.pending", split_pending, 1'b0);
      trans_done = 1'b1;
      tick("m1_done4");
      m1_request = 1'b0; m2_request = 1'b0;
      tick("idle5");

      // Timeout: grant held TO cycles, then a one-cycle timeout_err.
      m1_request = 1'b1;
      tick("to_grant");
      for (int i = 0; i < int'(TO) - 1; i++) begin
         tick("to_hold");
         check("to_hold.grant", m1_grant, 1'b1);
      end
      tick("to_fire");
      check("to_fire.err", timeout_err, 1'b1);
      check("to_fire.grant", m1_grant, 1'b0);
      m1_request = 1'b0;
      tick("to_after");
      check("to_after.err", timeout_err, 1'b0);

      // trans_done beats a coincident split_enable.
      m2_request = 1'b1;
      tick("td_split_own");
      trans_done = 1'b1; split_enable = 1'b1;
      tick("td_split");
      check("td_split.pending", split_pending, 1'b0);
      m2_request = 1'b0;
      tick("idle6");

      // Stray release ignored, then reset mid-grant with a split pending.
      split_release = 1'b1;
      tick("stray_release");
      m1_request = 1'b1;
      tick("m1_own5");
      split_enable = 1'b1;
      tick("m1_split5");
      m2_request = 1'b1;
      tick("m2_own5");
      reset = 1'b1;
      #1;
      model_reset();
      check_all("reset_mid");
      tick("reset_mid_hold");
      reset = 1'b0;
      tick("post_reset");
      check("post_reset.m1", m1_grant, 1'b1);
      m1_request = 1'b0; m2_request = 1'b0;
      tick("idle7");

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(7) == 0) m1_request = ~m1_request;
         if ($urandom_range(7) == 0) m2_request = ~m2_request;
         trans_done    = ($urandom_range(9) == 0);
         split_enable  = ($urandom_range(11) == 0);
         split_release = ($urandom_range(9) == 0);
         reset         = ($urandom_range(99) == 0);
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
